// File: rtl/wf8_mem_pkg.sv
// wf8_mem_pkg: shared memory-path constants and LSU state encoding
package wf8_mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} lsu_state_t;
endpackage

// File: rtl/ram_lsu_if.sv
// ram_lsu_if: core request/response and RAM port bundle around the LSU
interface ram_lsu_if;
  import wf8_mem_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr_a;
  logic [ADDR_W-1:0] req_addr_b;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data_a;
  logic [DATA_W-1:0] rsp_data_b;
  logic [ADDR_W-1:0] ram_addr_1;
  logic [ADDR_W-1:0] ram_addr_2;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata_1;
  logic [DATA_W-1:0] ram_rdata_2;
  logic              busy;
  modport slave (
    input  req_valid, req_we, req_addr_a, req_addr_b, req_wdata, rsp_ready, ram_rdata_1, ram_rdata_2,
    output req_ready, rsp_valid, rsp_data_a, rsp_data_b, ram_addr_1, ram_addr_2, ram_wdata, ram_we, busy
  );
  modport master (
    output req_valid, req_we, req_addr_a, req_addr_b, req_wdata, rsp_ready, ram_rdata_1, ram_rdata_2,
    input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, ram_addr_1, ram_addr_2, ram_wdata, ram_we, busy
  );
endinterface

// File: rtl/ram_lsu.sv
// ram_lsu: load/store front-end mapping core requests onto the 256x8 ram
module ram_lsu
  import wf8_mem_pkg::*;
(
  input logic       clk,
  input logic       rst,
  ram_lsu_if.slave  bus
);
  lsu_state_t        r_state;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic [ADDR_W-1:0] r_addr_1;
  logic [ADDR_W-1:0] r_addr_2;
  logic [DATA_W-1:0] r_wdata;
  logic              w_ready;
  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr_1;
  logic [ADDR_W-1:0] w_addr_2;
  logic [DATA_W-1:0] w_wdata;
  // ready is gated by reset so ram_we can never fire while held in reset
  always_comb begin
    w_ready  = rst && ((r_state == IDLE) || (r_state == RESP && bus.rsp_ready));
    w_accept = bus.req_valid && w_ready;
    w_wr     = w_accept && bus.req_we;
    w_rd     = w_accept && !bus.req_we;
    w_addr_1 = w_accept ? bus.req_addr_a : r_addr_1;
    w_addr_2 = w_wr ? bus.req_addr_a : w_rd ? bus.req_addr_b : r_addr_2;
    w_wdata  = w_wr ? bus.req_wdata : r_wdata;
  end
  assign bus.req_ready  = w_ready;
  assign bus.ram_we     = w_wr;
  assign bus.ram_addr_1 = w_addr_1;
  assign bus.ram_addr_2 = w_addr_2;
  assign bus.ram_wdata  = w_wdata;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data_a = r_data_a;
  assign bus.rsp_data_b = r_data_b;
  assign bus.busy       = (r_state != IDLE);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_addr_1    <= '0;
      r_addr_2    <= '0;
      r_wdata     <= '0;
    end else begin
      r_addr_1 <= w_addr_1;
      r_addr_2 <= w_addr_2;
      r_wdata  <= w_wdata;
      case (r_state)
        IDLE: r_state <= w_rd ? WAIT : IDLE;
        WAIT: begin
          r_data_a    <= bus.ram_rdata_1;
          r_data_b    <= bus.ram_rdata_2;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= w_rd ? WAIT : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: directed self-checking bench for ram_lsu with a behavioural 256x8 ram
module tb_ram_lsu;
  import wf8_mem_pkg::*;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [DATA_W-1:0] mem [0:255];
  ram_lsu_if bus ();
  ram_lsu dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // ram model: registered reads, write at the edge, port 2 reads 0 after a write
  always_ff @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr_2] <= bus.ram_wdata;
    bus.ram_rdata_1 <= mem[bus.ram_addr_1];
    bus.ram_rdata_2 <= bus.ram_we ? '0 : mem[bus.ram_addr_2];
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr_a = a;
    bus.req_addr_b = 8'h00;
    bus.req_wdata  = d;
    tick();
    bus.req_valid  = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] ea, input logic [7:0] eb);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    tick();
    bus.req_valid  = 1'b0;
    chk({tag, "_wait_valid"}, bus.rsp_valid, 0);
    tick();
    chk({tag, "_valid"}, bus.rsp_valid, 1);
    chk({tag, "_a"}, bus.rsp_data_a, ea);
    chk({tag, "_b"}, bus.rsp_data_b, eb);
    tick();
    chk({tag, "_done"}, bus.rsp_valid, 0);
  endtask
  logic [7:0] tp_a  [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'hFF};
  logic [7:0] tp_b  [8] = '{8'hFF, 8'h20, 8'h11, 8'h10, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] tp_ea [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h3C, 8'h5A, 8'h77};
  logic [7:0] tp_eb [8] = '{8'h77, 8'h5A, 8'h3C, 8'hA5, 8'h04, 8'h03, 8'h02, 8'h01};
  initial begin
    int nresp;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr_a = '0;
    bus.req_addr_b = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    tick();
    tick();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_data_a", bus.rsp_data_a, 0);
    chk("rst_data_b", bus.rsp_data_b, 0);
    rst = 1'b1;
    #1;
    chk("rst_rel_ready", bus.req_ready, 1);
    // write then read
    wr(8'h11, 8'h3C);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr_a = 8'h10;
    bus.req_wdata  = 8'hA5;
    #1;
    chk("wr_ram_we", bus.ram_we, 1);
    chk("wr_addr_2", bus.ram_addr_2, 8'h10);
    chk("wr_addr_1", bus.ram_addr_1, 8'h10);
    chk("wr_wdata", bus.ram_wdata, 8'hA5);
    tick();
    bus.req_we     = 1'b0;
    bus.req_addr_a = 8'h10;
    bus.req_addr_b = 8'h11;
    #1;
    chk("rd_ram_we", bus.ram_we, 0);
    chk("rd_addr_1", bus.ram_addr_1, 8'h10);
    chk("rd_addr_2", bus.ram_addr_2, 8'h11);
    tick();
    bus.req_valid = 1'b0;
    chk("rd_busy", bus.busy, 1);
    chk("rd_ready_wait", bus.req_ready, 0);
    chk("rd_valid_n1", bus.rsp_valid, 0);
    tick();
    chk("rd_valid_n2", bus.rsp_valid, 1);
    chk("rd_data_a", bus.rsp_data_a, 8'hA5);
    chk("rd_data_b", bus.rsp_data_b, 8'h3C);
    tick();
    chk("rd_consumed", bus.rsp_valid, 0);
    chk("rd_idle_busy", bus.busy, 0);
    // back-to-back writes
    for (int i = 0; i < 4; i++) begin
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_addr_a = 8'(i);
      bus.req_wdata  = 8'(i + 1);
      #1;
      chk("b2b_ready", bus.req_ready, 1);
      chk("b2b_we", bus.ram_we, 1);
      chk("b2b_addr_2", bus.ram_addr_2, i);
      chk("b2b_rsp_valid", bus.rsp_valid, 0);
      tick();
    end
    bus.req_valid = 1'b0;
    #1;
    chk("b2b_we_off", bus.ram_we, 0);
    chk("b2b_addr_hold", bus.ram_addr_2, 8'h03);
    chk("b2b_no_rsp", bus.rsp_valid, 0);
    // backpressure
    wr(8'h20, 8'h5A);
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr_a = 8'h20;
    bus.req_addr_b = 8'h20;
    tick();
    bus.req_addr_a = 8'h10;
    bus.req_addr_b = 8'h11;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data_a", bus.rsp_data_a, 8'h5A);
      chk("bp_data_b", bus.rsp_data_b, 8'h5A);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_addr_hold", bus.ram_addr_1, 8'h20);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready, 1);
    chk("bp_release_addr", bus.ram_addr_1, 8'h10);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_next_wait", bus.rsp_valid, 0);
    chk("bp_next_busy", bus.busy, 1);
    tick();
    chk("bp_next_valid", bus.rsp_valid, 1);
    chk("bp_next_a", bus.rsp_data_a, 8'hA5);
    chk("bp_next_b", bus.rsp_data_b, 8'h3C);
    tick();
    // async reset mid-WAIT
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr_a = 8'h20;
    bus.req_addr_b = 8'h20;
    tick();
    bus.req_valid = 1'b0;
    chk("ar_in_wait", bus.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", bus.rsp_valid, 0);
    chk("ar_busy", bus.busy, 0);
    tick();
    chk("ar_held_valid", bus.rsp_valid, 0);
    rst = 1'b1;
    #1;
    chk("ar_rel_ready", bus.req_ready, 1);
    tick();
    chk("ar_no_rsp", bus.rsp_valid, 0);
    chk("ar_rel_busy", bus.busy, 0);
    rd("ar_after", 8'h20, 8'h20, 8'h5A, 8'h5A);
    // wrap and idle
    wr(8'hFF, 8'h77);
    rd("wrap", 8'hFF, 8'h00, 8'h77, 8'h01);
    for (int i = 0; i < 4; i++) begin
      chk("idle_we", bus.ram_we, 0);
      tick();
    end
    // throughput: a new read accepted in each response cycle
    nresp = 0;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr_a = tp_a[0];
    bus.req_addr_b = tp_b[0];
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("tp_wait", bus.rsp_valid, 0);
      if (k < 7) begin
        bus.req_addr_a = tp_a[k+1];
        bus.req_addr_b = tp_b[k+1];
      end else begin
        bus.req_valid = 1'b0;
      end
      tick();
      chk("tp_valid", bus.rsp_valid, 1);
      chk("tp_data_a", bus.rsp_data_a, tp_ea[k]);
      chk("tp_data_b", bus.rsp_data_b, tp_eb[k]);
      if (bus.rsp_valid === 1'b1) nresp++;
    end
    chk("tp_count", nresp, 8);
    tick();
    chk("tp_end_idle", bus.busy, 0);
    chk("tp_end_valid", bus.rsp_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
